// File: rtl/pi_duty_regulator_if.sv
// Bundle between the PI duty regulator and its ADC front end and PWM stage.
// The master side is whatever drives samples and period timing; the slave is the regulator.
interface pi_duty_regulator_if #(
  parameter int ADC_W  = 12,
  parameter int DUTY_W = 10,
  parameter int K_W    = 8
);
  logic              en;
  logic              sample_valid;
  logic              sample_ready;
  logic [ADC_W-1:0]  sample_data;
  logic [ADC_W-1:0]  setpoint;
  logic [K_W-1:0]    kp;
  logic [K_W-1:0]    ki;
  logic [DUTY_W-1:0] period_max;
  logic              period_end;
  logic [DUTY_W-1:0] duty;
  logic              duty_valid;
  logic              sat;

  modport master (
    output en, sample_valid, sample_data, setpoint, kp, ki, period_max, period_end,
    input  sample_ready, duty, duty_valid, sat
  );

  modport slave (
    input  en, sample_valid, sample_data, setpoint, kp, ki, period_max, period_end,
    output sample_ready, duty, duty_valid, sat
  );
endinterface

// File: rtl/pi_duty_regulator.sv
// PI compensator feeding the dead-time PWM stage; one shared multiplier, with the
// duty result held pending until the PWM period boundary so a period never glitches.
module pi_duty_regulator #(
  parameter int ADC_W  = 12,
  parameter int DUTY_W = 10,
  parameter int K_W    = 8,
  parameter int FRAC   = 6,
  parameter int ACC_W  = 24
) (
  input logic                clk,
  input logic                resetn,
  pi_duty_regulator_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MUL_P = 2'd1;
  localparam logic [1:0] ST_MUL_I = 2'd2;
  localparam logic [1:0] ST_SUM   = 2'd3;

  logic [1:0]               state_r;
  logic signed [ADC_W:0]    err_r;
  logic signed [ACC_W-1:0]  prod_p_r;
  logic signed [ACC_W-1:0]  integ_r;
  logic [DUTY_W-1:0]        pending_r;
  logic                     pend_flag_r;
  logic [DUTY_W-1:0]        duty_r;
  logic                     duty_valid_r;
  logic                     sat_r;

  logic                     accept_s;
  logic [K_W-1:0]           gain_s;
  logic signed [ADC_W:0]    err_in_s;
  logic signed [ACC_W-1:0]  gain_ext_s;
  logic signed [ACC_W-1:0]  err_ext_s;
  logic signed [ACC_W-1:0]  prod_s;
  logic signed [ACC_W-1:0]  t_s;
  logic signed [ACC_W-1:0]  imax_s;
  logic signed [ACC_W-1:0]  integ_nx_s;
  logic signed [ACC_W-1:0]  sum_s;
  logic signed [ACC_W-1:0]  u_s;
  logic signed [ACC_W-1:0]  pmax_ext_s;
  logic [DUTY_W-1:0]        u_clamp_s;
  logic                     u_lo_s;
  logic                     u_hi_s;
  logic [DUTY_W-1:0]        duty_cap_s;
  logic [DUTY_W-1:0]        pend_cap_s;

  assign accept_s         = bus.en && bus.sample_valid && (state_r == ST_IDLE);
  assign bus.sample_ready = bus.en && (state_r == ST_IDLE);
  assign bus.duty         = duty_r;
  assign bus.duty_valid   = duty_valid_r;
  assign bus.sat          = sat_r;

  assign err_in_s   = $signed({1'b0, bus.setpoint}) - $signed({1'b0, bus.sample_data});
  assign gain_ext_s = $signed({{(ACC_W-K_W){1'b0}}, gain_s});
  assign err_ext_s  = {{(ACC_W-ADC_W-1){err_r[ADC_W]}}, err_r};
  assign prod_s     = gain_ext_s * err_ext_s;
  assign t_s        = integ_r + prod_s;
  assign imax_s     = $signed({{(ACC_W-DUTY_W-FRAC){1'b0}}, bus.period_max, {FRAC{1'b0}}});
  assign pmax_ext_s = $signed({{(ACC_W-DUTY_W){1'b0}}, bus.period_max});
  // integ_r already holds the MUL_I update when SUM evaluates this
  assign sum_s      = prod_p_r + integ_r;
  assign u_s        = sum_s >>> FRAC;
  assign u_lo_s     = u_s[ACC_W-1];
  assign u_hi_s     = (u_s > pmax_ext_s);

  // Shared multiplier operand: kp during MUL_P, ki otherwise
  always_comb begin
    gain_s = bus.ki;
    case (state_r)
      ST_MUL_P: gain_s = bus.kp;
      default:  gain_s = bus.ki;
    endcase
  end

  // Integrator anti-windup clamp to [0, period_max << FRAC]
  always_comb begin
    integ_nx_s = t_s;
    if (t_s[ACC_W-1]) begin
      integ_nx_s = {ACC_W{1'b0}};
    end else if (t_s > imax_s) begin
      integ_nx_s = imax_s;
    end else begin
      integ_nx_s = t_s;
    end
  end

  // Controller output clamp to [0, period_max]
  always_comb begin
    u_clamp_s = {DUTY_W{1'b0}};
    if (u_lo_s) begin
      u_clamp_s = {DUTY_W{1'b0}};
    end else if (u_hi_s) begin
      u_clamp_s = bus.period_max;
    end else begin
      u_clamp_s = u_s[DUTY_W-1:0];
    end
  end

  // Commit-time limiting so a shrinking period_max is honoured at the boundary
  always_comb begin
    duty_cap_s = duty_r;
    pend_cap_s = pending_r;
    if (duty_r > bus.period_max) begin
      duty_cap_s = bus.period_max;
    end else begin
      duty_cap_s = duty_r;
    end
    if (pending_r > bus.period_max) begin
      pend_cap_s = bus.period_max;
    end else begin
      pend_cap_s = pending_r;
    end
  end

  // Sequencer and datapath registers for one sample computation
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r  <= ST_IDLE;
      err_r    <= {(ADC_W+1){1'b0}};
      prod_p_r <= {ACC_W{1'b0}};
      integ_r  <= {ACC_W{1'b0}};
    end else if (!bus.en) begin
      state_r <= ST_IDLE;
      integ_r <= {ACC_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            err_r   <= err_in_s;
            state_r <= ST_MUL_P;
          end
        end
        ST_MUL_P: begin
          prod_p_r <= prod_s;
          state_r  <= ST_MUL_I;
        end
        ST_MUL_I: begin
          integ_r <= integ_nx_s;
          state_r <= ST_SUM;
        end
        ST_SUM:  state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Pending result capture and period-boundary commit to the PWM stage
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending_r    <= {DUTY_W{1'b0}};
      pend_flag_r  <= 1'b0;
      duty_r       <= {DUTY_W{1'b0}};
      duty_valid_r <= 1'b0;
      sat_r        <= 1'b0;
    end else if (!bus.en) begin
      pending_r    <= {DUTY_W{1'b0}};
      pend_flag_r  <= 1'b0;
      duty_r       <= {DUTY_W{1'b0}};
      duty_valid_r <= (duty_r != {DUTY_W{1'b0}});
      sat_r        <= 1'b0;
    end else begin
      duty_valid_r <= 1'b0;
      if (bus.period_end) begin
        if (pend_flag_r) begin
          duty_r       <= pend_cap_s;
          duty_valid_r <= 1'b1;
        end else begin
          duty_r <= duty_cap_s;
        end
      end
      // A result landing on the boundary cycle waits for the following boundary
      if (state_r == ST_SUM) begin
        pending_r   <= u_clamp_s;
        sat_r       <= u_lo_s || u_hi_s;
        pend_flag_r <= 1'b1;
      end else if (bus.period_end) begin
        pend_flag_r <= 1'b0;
      end
    end
  end

endmodule
